// File: rtl/feature_buf_arbiter.sv
// feature_buf_arbiter
// Access controller in front of the ping-pong feature SRAM (banks A and B).
// It owns buf_sel, routes the loader, layer read and layer write requesters onto
// the two single-port banks, and performs the layer-boundary buffer swap with a
// one-cycle drain.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   ld_valid/ld_ready/ld_addr/ld_data loader write port (targets read bank)
//   rd_valid/rd_ready/rd_addr         layer read request (targets read bank)
//   rd_data_valid/rd_data             read return, one cycle after accept
//   wr_valid/wr_ready/wr_addr/wr_data ofmap write port (targets write bank)
//   swap_req/swap_done                buffer flip request / completion pulse
//   buf_sel                           0: read A, write B; 1: read B, write A
//   addr_err                          sticky out-of-range indication
//   a_*/b_*                           bank A / bank B SRAM controls and read data
module feature_buf_arbiter #(
    parameter int DEPTH  = 12000,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              swap_req,
    output logic              swap_done,
    output logic              buf_sel,
    output logic              addr_err,
    output logic              a_we,
    output logic [ADDR_W-1:0] a_waddr,
    output logic [DATA_W-1:0] a_wdata,
    output logic [ADDR_W-1:0] a_raddr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_we,
    output logic [ADDR_W-1:0] b_waddr,
    output logic [DATA_W-1:0] b_wdata,
    output logic [ADDR_W-1:0] b_raddr,
    input  logic [DATA_W-1:0] b_rdata
);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_DRAIN  = 1'b1
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // Address is a valid entry of a bank.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              buf_sel_r;
    logic              swap_done_r;
    logic              rd_pend_r;
    logic              rd_oor_r;
    logic              rd_bank_r;
    logic              addr_err_r;
    logic              in_normal_s;
    logic              ld_acc_s;
    logic              rd_acc_s;
    logic              wr_acc_s;
    logic              ld_ok_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic [ADDR_W-1:0] rd_raddr_s;

    // Handshakes: readies depend only on state, rst and ld_valid; loader has priority on the read bank.
    always_comb begin
        in_normal_s = (state_r == ST_NORMAL) && !rst;
        ld_ready    = in_normal_s;
        rd_ready    = in_normal_s && !ld_valid;
        wr_ready    = in_normal_s;
        ld_acc_s    = ld_valid && ld_ready;
        rd_acc_s    = rd_valid && rd_ready;
        wr_acc_s    = wr_valid && wr_ready;
        ld_ok_s     = ld_acc_s && in_range(ld_addr);
        rd_ok_s     = rd_acc_s && in_range(rd_addr);
        wr_ok_s     = wr_acc_s && in_range(wr_addr);
        if (rd_ok_s) begin
            rd_raddr_s = rd_addr;
        end else begin
            rd_raddr_s = {ADDR_W{1'b0}};
        end
    end

    // Next-state: a swap request in NORMAL drains for exactly one cycle; requests in DRAIN are dropped.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (swap_req) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_DRAIN: state_nxt_s = ST_NORMAL;
            default:  state_nxt_s = ST_NORMAL;
        endcase
    end

    // Bank steering: the read bank takes loader writes and layer reads, the other bank takes ofmap writes.
    always_comb begin
        a_we    = 1'b0;
        a_waddr = {ADDR_W{1'b0}};
        a_wdata = {DATA_W{1'b0}};
        a_raddr = {ADDR_W{1'b0}};
        b_we    = 1'b0;
        b_waddr = {ADDR_W{1'b0}};
        b_wdata = {DATA_W{1'b0}};
        b_raddr = {ADDR_W{1'b0}};
        if (!buf_sel_r) begin
            a_we    = ld_ok_s;
            a_waddr = ld_addr;
            a_wdata = ld_data;
            a_raddr = rd_raddr_s;
            b_we    = wr_ok_s;
            b_waddr = wr_addr;
            b_wdata = wr_data;
        end else begin
            b_we    = ld_ok_s;
            b_waddr = ld_addr;
            b_wdata = ld_data;
            b_raddr = rd_raddr_s;
            a_we    = wr_ok_s;
            a_waddr = wr_addr;
            a_wdata = wr_data;
        end
    end

    // State, buffer select, swap pulse, read-return tracking and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_NORMAL;
            buf_sel_r   <= 1'b0;
            swap_done_r <= 1'b0;
            rd_pend_r   <= 1'b0;
            rd_oor_r    <= 1'b0;
            rd_bank_r   <= 1'b0;
            addr_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            swap_done_r <= (state_r == ST_DRAIN);
            if (state_r == ST_DRAIN) begin
                buf_sel_r <= ~buf_sel_r;
            end else begin
                buf_sel_r <= buf_sel_r;
            end
            rd_pend_r  <= rd_acc_s;
            rd_oor_r   <= rd_acc_s && !rd_ok_s;
            // Bank select is captured at accept so a return landing after a swap still uses the old bank.
            rd_bank_r  <= buf_sel_r;
            addr_err_r <= addr_err_r
                          || (ld_acc_s && !ld_ok_s)
                          || (rd_acc_s && !rd_ok_s)
                          || (wr_acc_s && !wr_ok_s);
        end
    end

    // Read return mux: zero when idle or when the accepted read was out of range.
    always_comb begin
        if (rd_pend_r && !rd_oor_r) begin
            if (rd_bank_r) begin
                rd_data = b_rdata;
            end else begin
                rd_data = a_rdata;
            end
        end else begin
            rd_data = {DATA_W{1'b0}};
        end
    end

    assign rd_data_valid = rd_pend_r;
    assign swap_done     = swap_done_r;
    assign buf_sel       = buf_sel_r;
    assign addr_err      = addr_err_r;

endmodule

// File: doc/feature_buf_arbiter.md
Name: feature_buf_arbiter

Overview:
Access controller that sits directly in front of the ping-pong feature SRAM (banks A/B) and owns the buf_sel state. It routes three requesters onto the two single-port banks: the mel-spectrogram input loader, the layer read port (ifmap fetch), and the layer write port (ofmap store). It also performs the layer-boundary buffer swap with a drain handshake, so the layer controller never drives bank pins directly.

Parameters:
DEPTH, 12000, valid entries per bank; addresses >= DEPTH are out of range
DATA_W, 8, feature word width (INT8)
ADDR_W, 14, address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ld_valid  in  1  loader write request
ld_ready  out  1  loader request accepted this cycle
ld_addr  in  ADDR_W  loader address
ld_data  in  DATA_W  loader data
rd_valid  in  1  layer read request
rd_ready  out  1  read accepted this cycle
rd_addr  in  ADDR_W  read address
rd_data_valid  out  1  read data returned (one cycle after accept)
rd_data  out  DATA_W  read data
wr_valid  in  1  ofmap write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
swap_req  in  1  single-cycle pulse: flip buffers
swap_done  out  1  single-cycle pulse: flip completed
buf_sel  out  1  0: read bank A / write bank B; 1: read B / write A
addr_err  out  1  sticky: an out-of-range request was accepted
a_we, a_waddr, a_wdata, a_raddr  out  1/ADDR_W/DATA_W/ADDR_W  bank A controls
a_rdata  in  DATA_W  bank A read data (synchronous, valid one cycle after a_raddr)
b_we, b_waddr, b_wdata, b_raddr  out  1/ADDR_W/DATA_W/ADDR_W  bank B controls
b_rdata  in  DATA_W  bank B read data

Behaviour:
- Reset (rst high at a clk edge): state=NORMAL, buf_sel=0, swap_done=0, rd_data_valid=0, rd_data=0, addr_err=0. While rst is high, all readies=0 and a_we=b_we=0.
- Bank roles: read bank = buf_sel ? B : A; write bank = the other bank. The loader and the read port both target the read bank. The write port targets the write bank.
- States:
  - NORMAL: ld_ready=1; rd_ready=~ld_valid (loader has fixed priority on the read bank); wr_ready=1.
  - DRAIN: all readies=0; lasts exactly one cycle.
- Readies are combinational from the state and ld_valid only. They never depend on the corresponding valid.
- Bank drive:
  - Write bank: we = wr accepted.
  - Read bank: we = ld accepted.
  - Accepted rd drives the read bank's raddr; otherwise raddr holds 0.
  - Each bank performs at most one access per cycle. The read bank never sees a read and a write in the same cycle.
- Read return: rd accepted at cycle t gives rd_data_valid=1 at t+1. rd_data is taken from the bank that was the read bank at t, using a registered bank select, so it is correct even across a swap. rd_data is 0 whenever rd_data_valid=0.
- Out-of-range address (addr >= DEPTH):
  - The handshake still completes.
  - For writes, we is suppressed.
  - For reads, raddr is driven to 0, and rd_data_valid=1 with rd_data=0 at t+1.
  - addr_err is set at the next edge and is cleared only by rst.
- Swap sequence:
  - swap_req in NORMAL at cycle t: accepts at t still proceed; the next state is DRAIN.
  - t+1 (DRAIN): no new accepts; any read accepted at t returns its data.
  - At the t+1 edge: buf_sel toggles and the state returns to NORMAL.
  - t+2: swap_done=1 for one cycle; new accepts use the new buf_sel.
  - swap_req while in DRAIN is ignored and not queued.
- Simultaneous ld_valid and rd_valid in NORMAL: ld is accepted, rd waits. Requesters hold valid/addr/data stable until accepted.
- rst during DRAIN: buf_sel returns to 0; no swap_done pulse; any pending rd_data_valid is cleared.

Test Plan:
1. Reset: assert rst 2 cycles with all valids=1 -> readies=0, a_we=b_we=0, buf_sel=0, rd_data_valid=0, addr_err=0.
2. Load then read (buf_sel=0):
   - Loader writes addr 5 = 0x3C -> a_we=1, a_waddr=5, a_wdata=0x3C, b_we=0.
   - Then rd addr 5 (bank model returns 0x3C) -> rd_data_valid=1, rd_data=0x3C exactly one cycle after accept.
3. Contention and concurrency:
   - ld_valid and rd_valid together -> ld_ready=1, rd_ready=0.
   - Same cycle wr addr 11999 = 0x7F -> b_we=1, b_waddr=11999.
   - Next cycle (ld_valid=0) -> rd accepted.
4. Swap timing: rd accepted at cycle t with swap_req=1 at t.
   - t+1: readies=0; rd_data comes from bank A.
   - t+2: buf_sel=1, swap_done=1.
   - rd addr 5 at t+2 -> drives b_raddr=5.
   - A second swap_req at t+1 has no effect.
5. Address error: wr addr 12000 -> wr_ready=1, no we on either bank, addr_err=1 from next cycle. rd addr 13000 -> rd_data_valid=1, rd_data=0.
6. Reset mid-swap: swap_req at t, rst at t+1 -> buf_sel=0 and swap_done=0 after reset; normal operation resumes with bank A as the read bank.
